// File: rtl/bridge_pkg.sv
// Shared types and constants for the multi-slave CPU bridge.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // Byte offsets of the bridge's own registers from BR_BASE.
  localparam logic [3:0] OFF_PEND = 4'h0;
  localparam logic [3:0] OFF_MASK = 4'h4;
  localparam logic [3:0] OFF_ERR  = 4'h8;

  localparam int HWINT_W = 6;

endpackage

// File: rtl/multi_slave_bridge_irq_ctrl.sv
// Interrupt synchronisers, pending/mask registers and the registered HWInt vector.
module irq_ctrl
  import bridge_pkg::*;
#(
  parameter int                 N_IRQ    = 6,
  parameter logic [HWINT_W-1:0] IRQ_EDGE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_IRQ-1:0]   irq,
  input  logic               pend_we,
  input  logic               mask_we,
  input  logic [HWINT_W-1:0] wd,
  output logic [HWINT_W-1:0] pend,
  output logic [HWINT_W-1:0] mask,
  output logic [HWINT_W-1:0] hw_int
);

  logic [HWINT_W-1:0] irq_w, sync1, sync2, sync_d;
  logic [HWINT_W-1:0] rise, clr, pend_next, mask_next;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    irq_w = '0;
    irq_w[N_IRQ-1:0] = irq;
  end

  assign rise      = sync2 & ~sync_d;
  assign clr       = pend_we ? (wd & IRQ_EDGE) : '0;
  // A set event outranks a same-cycle clear on edge bits.
  assign pend_next = (IRQ_EDGE & ((pend & ~clr) | rise)) | (~IRQ_EDGE & sync2);
  assign mask_next = mask_we ? wd : mask;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      sync_d <= '0;
      pend   <= '0;
      mask   <= '1;
      hw_int <= '0;
    end else begin
      sync1  <= irq_w;
      sync2  <= sync1;
      sync_d <= sync2;
      pend   <= pend_next;
      mask   <= mask_next;
      hw_int <= pend_next & mask_next;
    end
  end

endmodule

// File: rtl/multi_slave_bridge.sv
// CPU-to-slave bridge: window decode, req/ack handshake with timeout, own register window.
module multi_slave_bridge
  import bridge_pkg::*;
#(
  parameter int                   N_SLV    = 4,
  parameter logic [N_SLV*32-1:0]  SLV_LO   = {32'h7F20, 32'h7F10, 32'h7F00, 32'h0000},
  parameter logic [N_SLV*32-1:0]  SLV_HI   = {32'h7F2F, 32'h7F1B, 32'h7F0B, 32'h2FFF},
  parameter logic [31:0]          BR_BASE  = 32'h7F40,
  parameter int                   N_IRQ    = 6,
  parameter logic [HWINT_W-1:0]   IRQ_EDGE = 6'b000000,
  parameter int                   TIMEOUT  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pr_req,
  input  logic [31:0]          pr_addr,
  input  logic [3:0]           pr_be,
  input  logic [31:0]          pr_wd,
  input  logic                 pr_we,
  input  logic [31:0]          pr_pc,
  output logic                 pr_ack,
  output logic [31:0]          pr_rd,
  output logic                 pr_err,
  output logic [N_SLV-1:0]     slv_sel,
  output logic [31:0]          slv_addr,
  output logic [31:0]          slv_wd,
  output logic [3:0]           slv_be,
  output logic                 slv_we,
  output logic [31:0]          slv_pc,
  input  logic [N_SLV*32-1:0]  slv_rd,
  input  logic [N_SLV-1:0]     slv_ready,
  input  logic [N_IRQ-1:0]     irq,
  output logic [HWINT_W-1:0]   hw_int
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        err_addr;
  logic [N_SLV-1:0]   hit_sel;
  logic               br_hit;
  logic [1:0]         br_widx;
  logic [31:0]        br_rdata;
  logic [31:0]        sel_rd;
  logic               ready_hit;
  logic               pend_we, mask_we;
  logic [HWINT_W-1:0] pend, mask;

  // Scanning downward lets the lowest-index window win on overlap.
  always_comb begin
    hit_sel = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (pr_addr >= SLV_LO[32*i +: 32] && pr_addr <= SLV_HI[32*i +: 32]) begin
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
      end
    end
  end

  assign br_hit  = (pr_addr >= BR_BASE) && (pr_addr <= BR_BASE + 32'hB);
  // Low nibble of the offset depends only on the low nibbles of address and base.
  assign br_widx = 2'((pr_addr[3:0] - BR_BASE[3:0]) >> 2);

  always_comb begin
    br_rdata = '0;
    if (br_widx == OFF_PEND[3:2])      br_rdata[HWINT_W-1:0] = pend;
    else if (br_widx == OFF_MASK[3:2]) br_rdata[HWINT_W-1:0] = mask;
    else if (br_widx == OFF_ERR[3:2])  br_rdata = err_addr;
  end

  assign pend_we = (state == IDLE) && pr_req && br_hit && pr_we && (br_widx == OFF_PEND[3:2]);
  assign mask_we = (state == IDLE) && pr_req && br_hit && pr_we && (br_widx == OFF_MASK[3:2]);

  always_comb begin
    sel_rd    = '0;
    ready_hit = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (slv_sel[i]) begin
        sel_rd    = sel_rd | slv_rd[32*i +: 32];
        ready_hit = ready_hit | slv_ready[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      err_addr <= '0;
      pr_ack   <= 1'b0;
      pr_err   <= 1'b0;
      pr_rd    <= '0;
      slv_sel  <= '0;
      slv_we   <= 1'b0;
      slv_addr <= '0;
      slv_wd   <= '0;
      slv_be   <= '0;
      slv_pc   <= '0;
    end else begin
      case (state)
        IDLE: if (pr_req) begin
          slv_addr <= pr_addr;
          slv_wd   <= pr_wd;
          slv_be   <= pr_be;
          slv_pc   <= pr_pc;
          cnt      <= '0;
          if (br_hit) begin
            pr_rd  <= br_rdata;
            pr_err <= 1'b0;
            pr_ack <= 1'b1;
            state  <= RESP;
          end else if (|hit_sel) begin
            slv_sel <= hit_sel;
            slv_we  <= pr_we;
            state   <= ACCESS;
          end else begin
            pr_rd    <= '0;
            pr_err   <= 1'b1;
            pr_ack   <= 1'b1;
            err_addr <= pr_addr;
            state    <= RESP;
          end
        end
        ACCESS: begin
          if (ready_hit) begin
            pr_rd   <= sel_rd;
            pr_err  <= 1'b0;
            pr_ack  <= 1'b1;
            slv_sel <= '0;
            slv_we  <= 1'b0;
            state   <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            pr_rd    <= '0;
            pr_err   <= 1'b1;
            pr_ack   <= 1'b1;
            err_addr <= slv_addr;
            slv_sel  <= '0;
            slv_we   <= 1'b0;
            state    <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          pr_ack <= 1'b0;
          pr_err <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  irq_ctrl #(
    .N_IRQ    (N_IRQ),
    .IRQ_EDGE (IRQ_EDGE)
  ) u_irq_ctrl (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .pend_we (pend_we),
    .mask_we (mask_we),
    .wd      (pr_wd[HWINT_W-1:0]),
    .pend    (pend),
    .mask    (mask),
    .hw_int  (hw_int)
  );

endmodule

// File: tb/tb_multi_slave_bridge.sv
// Directed bench for multi_slave_bridge: decode, wait states, timeout, registers, IRQ, reset.
module tb_multi_slave_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic         pr_req;
  logic [31:0]  pr_addr, pr_wd, pr_pc;
  logic [3:0]   pr_be;
  logic         pr_we;
  logic         pr_ack, pr_err;
  logic [31:0]  pr_rd;
  logic [3:0]   slv_sel;
  logic [31:0]  slv_addr, slv_wd, slv_pc;
  logic [3:0]   slv_be;
  logic         slv_we;
  logic [127:0] slv_rd;
  logic [3:0]   slv_ready;
  logic [5:0]   irq;
  logic [5:0]   hw_int;

  int total = 0;
  int bad   = 0;

  logic [31:0] b_rd;
  logic        b_err;
  int          b_ack_cyc, b_sel_cyc, b_we_bad, b_resp_sel;
  logic [3:0]  b_sel_seen;
  logic [31:0] lat_addr, lat_wd, lat_pc;

  multi_slave_bridge #(.IRQ_EDGE(6'b000010)) dut (
    .clk(clk), .reset(reset),
    .pr_req(pr_req), .pr_addr(pr_addr), .pr_be(pr_be), .pr_wd(pr_wd),
    .pr_we(pr_we), .pr_pc(pr_pc), .pr_ack(pr_ack), .pr_rd(pr_rd), .pr_err(pr_err),
    .slv_sel(slv_sel), .slv_addr(slv_addr), .slv_wd(slv_wd), .slv_be(slv_be),
    .slv_we(slv_we), .slv_pc(slv_pc), .slv_rd(slv_rd), .slv_ready(slv_ready),
    .irq(irq), .hw_int(hw_int)
  );

  always #5 clk = ~clk;

  // Cycle 1 is the cycle in which pr_req is first driven; the slave model answers
  // rdy_mask after `waits` select cycles (waits < 0: never).
  task automatic bus(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                     input logic [3:0] rdy_mask, input int waits);
    int  wcnt;
    bit  done;
    @(posedge clk); #1;
    pr_req = 1'b1; pr_addr = addr; pr_we = we; pr_wd = wd; pr_be = 4'hF;
    pr_pc  = 32'h0040_0000 ^ addr;
    b_ack_cyc = 1; b_sel_cyc = 0; b_sel_seen = '0; b_we_bad = 0; b_resp_sel = 0;
    b_rd = '0; b_err = 1'b0; wcnt = 0; done = 1'b0;
    lat_addr = '0; lat_wd = '0; lat_pc = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      b_ack_cyc++;
      if (pr_ack) begin
        b_rd = pr_rd; b_err = pr_err; done = 1'b1;
        if (slv_sel !== 4'b0) b_resp_sel++;
        slv_ready = '0;
      end else if (slv_sel !== 4'b0) begin
        if (b_sel_cyc == 0) begin lat_addr = slv_addr; lat_wd = slv_wd; lat_pc = slv_pc; end
        b_sel_cyc++;
        b_sel_seen = b_sel_seen | slv_sel;
        if (slv_we !== we) b_we_bad++;
        slv_ready = (waits >= 0 && wcnt == waits) ? rdy_mask : 4'b0;
        wcnt++;
      end
    end
    pr_req = 1'b0; slv_ready = '0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL bus_no_ack addr=%h got no pr_ack want pr_ack within 40 cycles", addr);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; pr_req = 1'b0; pr_addr = '0; pr_wd = '0; pr_be = '0; pr_we = 1'b0;
    pr_pc = '0; slv_ready = '0; irq = '0;
    slv_rd = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({pr_ack, pr_err, slv_we, slv_sel, hw_int} !== 13'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0", {pr_ack, pr_err, slv_we, slv_sel, hw_int});
    end
    total++;
    if ({pr_rd, slv_addr, slv_wd, slv_be, slv_pc} !== 132'b0) begin
      bad++;
      $display("FAIL reset_data got rd=%h addr=%h wd=%h be=%h pc=%h want all 0",
               pr_rd, slv_addr, slv_wd, slv_be, slv_pc);
    end
    reset = 1'b1;
    bus(32'h7F44, 1'b0, '0, 4'b0, -1);
    total++;
    if (b_rd !== 32'h3F) begin bad++; $display("FAIL reset_mask got=%h want=%h", b_rd, 32'h3F); end
  endtask

  task automatic test_slave_read;
    bus(32'h1004, 1'b0, '0, 4'b0001, 0);
    total++;
    if (b_ack_cyc != 3) begin bad++; $display("FAIL rd_latency got=%0d want=3", b_ack_cyc); end
    total++;
    if (b_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h want=deadbeef", b_rd); end
    total++;
    if (b_err !== 1'b0) begin bad++; $display("FAIL rd_err got=%b want=0", b_err); end
    total++;
    if (b_sel_cyc != 1 || b_sel_seen !== 4'b0001 || b_resp_sel != 0) begin
      bad++;
      $display("FAIL rd_sel got cycles=%0d sel=%b resp_sel=%0d want cycles=1 sel=0001 resp_sel=0",
               b_sel_cyc, b_sel_seen, b_resp_sel);
    end
    total++;
    if (lat_addr !== 32'h1004) begin bad++; $display("FAIL rd_addr got=%h want=1004", lat_addr); end
  endtask

  task automatic test_slave_write;
    bus(32'h7F04, 1'b1, 32'h55, 4'b0010, 4);
    total++;
    if (b_sel_cyc != 5 || b_sel_seen !== 4'b0010) begin
      bad++;
      $display("FAIL wr_sel got cycles=%0d sel=%b want cycles=5 sel=0010", b_sel_cyc, b_sel_seen);
    end
    total++;
    if (b_we_bad != 0) begin bad++; $display("FAIL wr_we got bad_cycles=%0d want=0", b_we_bad); end
    total++;
    if (b_ack_cyc != 7 || b_err !== 1'b0) begin
      bad++;
      $display("FAIL wr_ack got cyc=%0d err=%b want cyc=7 err=0", b_ack_cyc, b_err);
    end
    total++;
    if (lat_addr !== 32'h7F04 || lat_wd !== 32'h55 || lat_pc !== (32'h0040_0000 ^ 32'h7F04)) begin
      bad++;
      $display("FAIL wr_latch got addr=%h wd=%h pc=%h want addr=7f04 wd=55 pc=%h",
               lat_addr, lat_wd, lat_pc, 32'h0040_0000 ^ 32'h7F04);
    end
  endtask

  task automatic test_unmapped;
    bus(32'h5000, 1'b0, '0, 4'b0, -1);
    total++;
    if (b_ack_cyc != 2 || b_err !== 1'b1 || b_rd !== 32'h0) begin
      bad++;
      $display("FAIL unmap_resp got cyc=%0d err=%b rd=%h want cyc=2 err=1 rd=0", b_ack_cyc, b_err, b_rd);
    end
    total++;
    if (b_sel_cyc != 0) begin bad++; $display("FAIL unmap_sel got=%0d want=0", b_sel_cyc); end
    bus(32'h7F48, 1'b0, '0, 4'b0, -1);
    total++;
    if (b_rd !== 32'h5000 || b_err !== 1'b0 || b_ack_cyc != 2) begin
      bad++;
      $display("FAIL unmap_erraddr got rd=%h err=%b cyc=%0d want rd=5000 err=0 cyc=2", b_rd, b_err, b_ack_cyc);
    end
  endtask

  task automatic test_timeout;
    bus(32'h7F10, 1'b0, '0, 4'b0100, -1);
    total++;
    if (b_sel_cyc != 16 || b_sel_seen !== 4'b0100) begin
      bad++;
      $display("FAIL to_sel got cycles=%0d sel=%b want cycles=16 sel=0100", b_sel_cyc, b_sel_seen);
    end
    total++;
    if (b_ack_cyc != 18 || b_err !== 1'b1 || b_rd !== 32'h0) begin
      bad++;
      $display("FAIL to_resp got cyc=%0d err=%b rd=%h want cyc=18 err=1 rd=0", b_ack_cyc, b_err, b_rd);
    end
    bus(32'h7F48, 1'b0, '0, 4'b0, -1);
    total++;
    if (b_rd !== 32'h7F10) begin bad++; $display("FAIL to_erraddr got=%h want=7f10", b_rd); end
  endtask

  task automatic test_irq;
    @(posedge clk); #1; irq[1] = 1'b1;
    @(posedge clk); #1; irq[1] = 1'b0;
    @(posedge clk); #1;
    total++;
    if (hw_int !== 6'b0) begin bad++; $display("FAIL irq_early got=%b want=000000", hw_int); end
    @(posedge clk); #1;
    total++;
    if (hw_int !== 6'b000010) begin bad++; $display("FAIL irq_edge_set got=%b want=000010", hw_int); end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (hw_int !== 6'b000010) begin bad++; $display("FAIL irq_edge_hold got=%b want=000010", hw_int); end
    bus(32'h7F40, 1'b0, '0, 4'b0, -1);
    total++;
    if (b_rd !== 32'h2) begin bad++; $display("FAIL irq_pend_rd got=%h want=2", b_rd); end
    bus(32'h7F40, 1'b1, 32'h2, 4'b0, -1);
    total++;
    if (hw_int !== 6'b0) begin bad++; $display("FAIL irq_w1c got=%b want=000000", hw_int); end
    irq[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (hw_int !== 6'b000001) begin bad++; $display("FAIL irq_level got=%b want=000001", hw_int); end
    bus(32'h7F40, 1'b0, '0, 4'b0, -1);
    total++;
    if (b_rd !== 32'h1) begin bad++; $display("FAIL irq_level_pend got=%h want=1", b_rd); end
    bus(32'h7F44, 1'b1, 32'h0, 4'b0, -1);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (hw_int !== 6'b0) begin bad++; $display("FAIL irq_masked got=%b want=000000", hw_int); end
    bus(32'h7F44, 1'b0, '0, 4'b0, -1);
    total++;
    if (b_rd !== 32'h0) begin bad++; $display("FAIL irq_mask_rd got=%h want=0", b_rd); end
    irq = '0;
  endtask

  task automatic test_reset_mid_access;
    @(posedge clk); #1;
    pr_req = 1'b1; pr_addr = 32'h1004; pr_we = 1'b1; pr_wd = 32'hA5; slv_ready = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (slv_sel !== 4'b0001) begin bad++; $display("FAIL mid_access_sel got=%b want=0001", slv_sel); end
    reset = 1'b0;
    #1;
    total++;
    if (slv_sel !== 4'b0 || pr_ack !== 1'b0 || slv_we !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got sel=%b ack=%b we=%b want sel=0000 ack=0 we=0", slv_sel, pr_ack, slv_we);
    end
    pr_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (pr_ack !== 1'b0) begin bad++; $display("FAIL mid_no_ack got=%b want=0", pr_ack); end
    bus(32'h7F44, 1'b0, '0, 4'b0, -1);
    total++;
    if (b_rd !== 32'h3F) begin bad++; $display("FAIL mid_mask_rst got=%h want=3f", b_rd); end
  endtask

  initial begin
    test_reset();
    test_slave_read();
    test_slave_write();
    test_unmapped();
    test_timeout();
    test_irq();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_slave_bridge.md
Name: multi_slave_bridge

Overview:
Parametrised system bridge between the CPU memory stage and N_SLV memory-mapped slaves (DM, Timer1, Timer2, spare). It decodes addresses through configurable windows and runs a req/ack handshake with per-slave wait states and a bus timeout. It also holds its own register window for interrupt pending/mask/error capture. It drives the 6-bit HWInt vector to CP0.

Parameters:
N_SLV, 4, number of slave channels (1..8)
SLV_LO, {32'h7F20,32'h7F10,32'h7F00,32'h0000}, packed N_SLV*32 window low bounds (slave i at [32i+31:32i])
SLV_HI, {32'h7F2F,32'h7F1B,32'h7F0B,32'h2FFF}, packed N_SLV*32 window high bounds, inclusive
BR_BASE, 32'h7F40, base of the bridge's own 3-word register window
N_IRQ, 6, interrupt inputs used (1..6); HWInt bits >= N_IRQ tied 0
IRQ_EDGE, 6'b000000, per-IRQ mode: 1 = rising-edge latched, 0 = level
TIMEOUT, 16, max wait cycles for slv_ready before bus error

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pr_req  in  1  CPU access request, held until pr_ack
pr_addr  in  32  byte address
pr_be  in  4  byte enables
pr_wd  in  32  write data
pr_we  in  1  1 = write, 0 = read
pr_pc  in  32  PC of the MEM-stage instruction
pr_ack  out  1  one-cycle completion pulse
pr_rd  out  32  read data, valid with pr_ack
pr_err  out  1  bus error, valid with pr_ack
slv_sel  out  N_SLV  one-hot slave select
slv_addr  out  32  latched address
slv_wd  out  32  latched write data
slv_be  out  4  latched byte enables
slv_we  out  1  write strobe; equals latched we while any slv_sel bit is set
slv_pc  out  32  latched PC
slv_rd  in  N_SLV*32  packed slave read data
slv_ready  in  N_SLV  per-slave completion
irq  in  N_IRQ  device interrupt lines (IRQ1 = irq[0])
hw_int  out  6  registered interrupt vector to CP0

Behaviour:
- Reset (reset=0, async): state IDLE; pr_ack, pr_err, slv_sel, slv_we, hw_int = 0; pr_rd, slv_addr, slv_wd, slv_be, slv_pc = 0; IRQ_MASK = 6'h3F; IRQ_PEND = 0; ERR_ADDR = 0; timeout counter = 0. An in-flight access is dropped with no ack.
- Decode: slave i is hit when SLV_LO_i <= addr <= SLV_HI_i. On overlapping windows the lowest index wins. The bridge window is BR_BASE..BR_BASE+0xB and takes priority over the slaves. Any other address is unmapped.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: when pr_req=1, latch addr/wd/be/we/pc and the decode result. Slave hit -> ACCESS. Bridge or unmapped -> RESP.
  - ACCESS: slv_sel = latched one-hot. Counter increments each cycle.
    - slv_ready[sel]=1 -> capture slv_rd[sel], go to RESP.
    - Counter reaches TIMEOUT -> set error, ERR_ADDR <= addr, go to RESP.
  - RESP: pr_ack=1 for one cycle, slv_sel=0, then IDLE.
- Latency: zero-wait slave = 3 cycles, request to ack. Bridge register or unmapped access = 2 cycles.
- The CPU must drop pr_req in the cycle after pr_ack. IDLE samples pr_req again from that cycle onward.
- Unmapped or timed-out access: pr_err=1, pr_rd=0, no slave written. ERR_ADDR captures the address.
- Bridge registers (word offsets):
  - 0x0 IRQ_PEND: read-only; write-1-to-clear on edge bits, writes ignored on level bits.
  - 0x4 IRQ_MASK: read/write, bits [5:0].
  - 0x8 ERR_ADDR: read-only.
  - Unused bits read 0. pr_be is ignored (full-word access).
- IRQ: each irq line passes through a 2-flop synchroniser.
  - Edge bits: a synced 0->1 sets PEND. A set event in the same cycle as a W1C clear wins (pending stays 1).
  - Level bits: PEND mirrors the synced input.
  - hw_int <= PEND & MASK, registered (3-cycle irq-to-hw_int latency).

Decomposition:
- Package bridge_pkg: state enum {IDLE, ACCESS, RESP}, register offsets (0x0/0x4/0x8), HWINT_W = 6.
- One sub-module, irq_ctrl: synchronisers, edge detect, PEND/MASK registers, hw_int output.
- Decode, FSM and datapath stay in the top module.

Test Plan:
- Read 0x1004, slv_ready[0] in the first ACCESS cycle, slv_rd[0]=32'hDEADBEEF -> pr_ack at cycle 3, pr_rd=DEADBEEF, pr_err=0, slv_sel=4'b0001 for one cycle.
- Write 0x7F04 wd=0x55, slv_ready[1] after 4 wait cycles -> slv_we=1 with slv_sel=4'b0010 for 5 cycles, then pr_ack.
- Read 0x5000 (unmapped) -> pr_ack at cycle 2, pr_err=1, pr_rd=0; reading 0x7F48 then returns 0x5000.
- slv_ready[2] never asserted on access to 0x7F10 -> pr_ack with pr_err=1 after TIMEOUT=16 ACCESS cycles.
- IRQ_EDGE=6'b000010: pulse irq[1] -> hw_int[1]=1 after 3 cycles and stays 1 after irq drops; write 0x2 to 0x7F40 -> hw_int[1]=0. Write 0 to IRQ_MASK -> hw_int=0 with level irq[0] high.
- Assert reset mid-ACCESS -> slv_sel and pr_ack go 0 immediately; after release, IRQ_MASK reads 0x3F.
